vga_scan_driver: RTL and testbench

// - Raster source and pixel sink for the sine/pattern layers. Generates 640x480@60 VGA timing
//   (25.175 MHz pixel clock) and issues tile coordinates (x 6b, y 5b) to a combinational layer.
// - Samples the layer's 6-bit colour (RR_GG_BB) one cycle later and drives registered

---
 rtl/vga_scan_driver_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_scan_driver.sv | 125 ++++++++++++
 tb/tb_vga_scan_driver.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_scan_driver_pkg.sv
// rtl/vga_scan_driver_pkg.sv - VGA 640x480@60 timing and RR_GG_BB colour constants
package vga_scan_driver_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int COLOUR_W = 6;
   localparam int R_HI = 5, R_LO = 4;
   localparam int G_HI = 3, G_LO = 2;
   localparam int B_HI = 1, B_LO = 0;

   typedef logic [COLOUR_W-1:0] colour_t;

   localparam colour_t BLACK = 6'b00_00_00;

   function automatic colour_t make_colour(input logic [1:0] r, input logic [1:0] g,
                                           input logic [1:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with active and sync decode
module vga_axis_counter #(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   localparam int TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] pos,
   output logic         wrap,
   output logic         active,
   output logic         sync_n
);

   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

   logic [W-1:0] pos_q, pos_d;

   always_comb begin
      wrap  = en && (pos_q == LAST);
      pos_d = pos_q;
      if (wrap) begin
         pos_d = '0;
      end else if (en) begin
         pos_d = pos_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos    = pos_q;
   assign active = pos_q < ACT_END;
   assign sync_n = !((pos_q >= SYNC_BEG) && (pos_q < SYNC_END));

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA raster source: window-to-tile mapping and aligned output stage
module vga_scan_driver
   import vga_scan_driver_pkg::*;
#(
   parameter int      H_ACTIVE    = VGA_H_ACTIVE,
   parameter int      H_FP        = VGA_H_FP,
   parameter int      H_SYNC      = VGA_H_SYNC,
   parameter int      H_BP        = VGA_H_BP,
   parameter int      V_ACTIVE    = VGA_V_ACTIVE,
   parameter int      V_FP        = VGA_V_FP,
   parameter int      V_SYNC      = VGA_V_SYNC,
   parameter int      V_BP        = VGA_V_BP,
   parameter int      WIN_X0      = 64,
   parameter int      WIN_Y0      = 152,
   parameter int      SCALE_SHIFT = 3,
   parameter int      WIN_COLS    = 64,
   parameter int      WIN_ROWS    = 22,
   parameter colour_t BG_COLOUR   = BLACK
) (
   input  logic       clk,
   input  logic       rst,
   output logic [5:0] layer_x,
   output logic [4:0] layer_y,
   output logic       layer_valid,
   input  logic [5:0] layer_rgb,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [5:0] rgb,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int V_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

   localparam logic [H_W-1:0] X0     = H_W'(WIN_X0);
   localparam logic [H_W-1:0] X_SPAN = H_W'(WIN_COLS << SCALE_SHIFT);
   localparam logic [V_W-1:0] Y0     = V_W'(WIN_Y0);
   localparam logic [V_W-1:0] Y_SPAN = V_W'(WIN_ROWS << SCALE_SHIFT);

   logic [H_W-1:0] hpos;
   logic [V_W-1:0] vpos;
   logic           h_wrap, v_wrap, h_active, v_active, h_sync_n, v_sync_n;

   vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
      .clk    (clk),
      .rst    (rst),
      .en     (1'b1),
      .pos    (hpos),
      .wrap   (h_wrap),
      .active (h_active),
      .sync_n (h_sync_n)
   );

   vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
      .clk    (clk),
      .rst    (rst),
      .en     (h_wrap),
      .pos    (vpos),
      .wrap   (v_wrap),
      .active (v_active),
      .sync_n (v_sync_n)
   );

   logic [H_W-1:0] wx;
   logic [V_W-1:0] wy;

   // The >= origin guard keeps positions left of/above the window from wrapping into it.
   always_comb begin
      wx          = hpos - X0;
      wy          = vpos - Y0;
      layer_valid = (hpos >= X0) && (wx < X_SPAN) && (vpos >= Y0) && (wy < Y_SPAN);
      layer_x     = 6'd0;
      layer_y     = 5'd0;
      if (layer_valid) begin
         layer_x = 6'(wx >> SCALE_SHIFT);
         layer_y = 5'(wy >> SCALE_SHIFT);
      end
   end

   logic    hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic    frame_tick_q, frame_tick_d;
   colour_t rgb_q, rgb_d;
   logic [7:0] frame_count_q, frame_count_d;

   // layer_rgb is only selected inside the window so undefined colour elsewhere stays out.
   always_comb begin
      hsync_d       = h_sync_n;
      vsync_d       = v_sync_n;
      de_d          = h_active && v_active;
      rgb_d         = BLACK;
      if (de_d) begin
         rgb_d = layer_valid ? layer_rgb : BG_COLOUR;
      end
      frame_tick_d  = v_wrap;
      frame_count_d = frame_count_q + {7'd0, v_wrap};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= BLACK;
         frame_tick_q  <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         frame_tick_q  <= frame_tick_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign rgb         = rgb_q;
   assign frame_tick  = frame_tick_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb/tb_vga_scan_driver.sv - directed bench: full-size timing on one instance, frame-level checks on a shrunk raster
module tb_vga_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Instance A: default 640x480 timing.
   logic       rst_a;
   logic [5:0] layer_x_a, layer_rgb_a, rgb_a;
   logic [4:0] layer_y_a;
   logic       layer_valid_a, hsync_a, vsync_a, de_a, frame_tick_a;
   logic [7:0] frame_count_a;

   vga_scan_driver dut_a (
      .clk         (clk),
      .rst         (rst_a),
      .layer_x     (layer_x_a),
      .layer_y     (layer_y_a),
      .layer_valid (layer_valid_a),
      .layer_rgb   (layer_rgb_a),
      .hsync       (hsync_a),
      .vsync       (vsync_a),
      .de          (de_a),
      .rgb         (rgb_a),
      .frame_tick  (frame_tick_a),
      .frame_count (frame_count_a)
   );

   // Instance B: 16x10 raster (12/1/2/1, 6/1/2/1), window x 2..9, y 1..4, 2x2 px tiles.
   logic       rst_b;
   logic [5:0] layer_x_b, layer_rgb_b, rgb_b;
   logic [4:0] layer_y_b;
   logic       layer_valid_b, hsync_b, vsync_b, de_b, frame_tick_b;
   logic [7:0] frame_count_b;
   logic       pattern_mode;

   vga_scan_driver #(
      .H_ACTIVE(12), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
      .WIN_X0(2), .WIN_Y0(1), .SCALE_SHIFT(1), .WIN_COLS(4), .WIN_ROWS(2),
      .BG_COLOUR(6'b00_01_01)
   ) dut_b (
      .clk         (clk),
      .rst         (rst_b),
      .layer_x     (layer_x_b),
      .layer_y     (layer_y_b),
      .layer_valid (layer_valid_b),
      .layer_rgb   (layer_rgb_b),
      .hsync       (hsync_b),
      .vsync       (vsync_b),
      .de          (de_b),
      .rgb         (rgb_b),
      .frame_tick  (frame_tick_b),
      .frame_count (frame_count_b)
   );

   // Stand-in layer: undefined colour outside the window.
   always_comb begin
      if (!layer_valid_b)    layer_rgb_b = 6'bxxxxxx;
      else if (pattern_mode) layer_rgb_b = {layer_x_b[1:0], layer_y_b[1:0], 2'b11};
      else                   layer_rgb_b = 6'b11_10_00;
   end

   function automatic logic [8:0] exp_b(input int i, input bit pat);
      int h, v, lx, ly;
      logic act, win, hs, vs;
      logic [5:0] col;
      h   = i % 16;
      v   = (i / 16) % 10;
      act = (h < 12) && (v < 6);
      win = (h >= 2) && (h < 10) && (v >= 1) && (v < 5);
      hs  = !((h >= 13) && (h < 15));
      vs  = !((v >= 7) && (v < 9));
      lx  = (h - 2) / 2;
      ly  = (v - 1) / 2;
      if (!act)     col = 6'd0;
      else if (!win) col = 6'b00_01_01;
      else if (pat) col = {lx[1:0], ly[1:0], 2'b11};
      else          col = 6'b11_10_00;
      return {hs, vs, act, col};
   endfunction

   task automatic reset_a(input int n);
      @(negedge clk);
      rst_a = 1'b1;
      repeat (n) @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic reset_b(input int n);
      @(negedge clk);
      rst_b = 1'b1;
      repeat (n) @(negedge clk);
      rst_b = 1'b0;
   endtask

   task automatic test_reset;
      reset_a(2);
      repeat (1900) @(negedge clk);
      n_total++;
      if (de_a !== 1'b1) $display("FAIL reset_pre_de: de=%b expected 1", de_a);
      else n_pass++;
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({hsync_a, vsync_a, de_a, rgb_a, frame_tick_a, frame_count_a, layer_valid_a, layer_x_a, layer_y_a}
          !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0, 1'b0, 6'd0, 5'd0})
         $display("FAIL reset_state: hs=%b vs=%b de=%b rgb=%b tick=%b cnt=%0d valid=%b expected 1 1 0 000000 0 0 0",
                  hsync_a, vsync_a, de_a, rgb_a, frame_tick_a, frame_count_a, layer_valid_a);
      else n_pass++;
      rst_a = 1'b0;
   endtask

   task automatic test_h_timing;
      int fall1, fall2, low_len, de_len, de_first, bad;
      logic prev_hs;
      fall1 = -1; fall2 = -1; low_len = 0; de_len = 0; de_first = -1; bad = 0;
      prev_hs = hsync_a;
      for (int k = 1; k <= 1700; k++) begin
         @(negedge clk);
         if (prev_hs && !hsync_a) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
         prev_hs = hsync_a;
         if (k <= 800 && !hsync_a) low_len++;
         if (k <= 800 && de_a) de_len++;
         if (de_a && de_first < 0) de_first = k;
         if (rgb_a !== 6'd0 || vsync_a !== 1'b1 || layer_valid_a !== 1'b0) bad++;
      end
      n_total++;
      if (de_first !== 1) $display("FAIL de_first: de rose at %0d expected 1", de_first);
      else n_pass++;
      n_total++;
      if (fall1 !== 657) $display("FAIL hsync_fall: fell at %0d expected 657", fall1);
      else n_pass++;
      n_total++;
      if (fall2 - fall1 !== 800) $display("FAIL hsync_period: %0d expected 800", fall2 - fall1);
      else n_pass++;
      n_total++;
      if (low_len !== 96) $display("FAIL hsync_width: %0d expected 96", low_len);
      else n_pass++;
      n_total++;
      if (de_len !== 640) $display("FAIL de_width: %0d expected 640", de_len);
      else n_pass++;
      n_total++;
      if (bad !== 0) $display("FAIL top_lines_bg: %0d bad cycles expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_window;
      int         pk[6];
      logic [11:0] pe[6];
      int         idx;
      pk = '{18, 33, 42, 52, 73, 85};
      pe = '{{1'b1, 6'd0, 5'd0}, 12'd0, 12'd0, {1'b1, 6'd1, 5'd1}, {1'b1, 6'd3, 5'd1}, 12'd0};
      reset_b(2);
      idx = 0;
      for (int j = 0; j < 6; j++) begin
         while (idx < pk[j]) begin
            @(negedge clk);
            idx++;
         end
         n_total++;
         if ({layer_valid_b, layer_x_b, layer_y_b} !== pe[j])
            $display("FAIL window_%0d: valid=%b x=%0d y=%0d expected %b %0d %0d", pk[j],
                     layer_valid_b, layer_x_b, layer_y_b, pe[j][11], pe[j][10:5], pe[j][4:0]);
         else n_pass++;
      end
   endtask

   task automatic test_colour(input bit pat);
      logic [8:0] e;
      pattern_mode = pat;
      reset_b(2);
      for (int k = 1; k <= 160; k++) begin
         @(negedge clk);
         e = exp_b(k - 1, pat);
         n_total++;
         if ({hsync_b, vsync_b, de_b, rgb_b} !== e)
            $display("FAIL colour_p%0d_i%0d: hs/vs/de/rgb=%b expected %b", pat, k - 1,
                     {hsync_b, vsync_b, de_b, rgb_b}, e);
         else n_pass++;
      end
   endtask

   task automatic test_frame;
      int ticks, misplaced, vs_first, vs_len;
      ticks = 0; misplaced = 0; vs_first = -1; vs_len = 0;
      reset_b(2);
      for (int k = 1; k <= 256 * 160; k++) begin
         @(negedge clk);
         if (frame_tick_b) begin
            ticks++;
            if (k % 160 != 0) misplaced++;
         end
         if (k <= 160 && !vsync_b) begin
            if (vs_first < 0) vs_first = k;
            vs_len++;
         end
         if (k == 160) begin
            n_total++;
            if ({frame_tick_b, frame_count_b} !== {1'b1, 8'd1})
               $display("FAIL first_wrap: tick=%b cnt=%0d expected 1 1", frame_tick_b, frame_count_b);
            else n_pass++;
         end
         if (k == 255 * 160) begin
            n_total++;
            if (frame_count_b !== 8'd255) $display("FAIL count_255: %0d expected 255", frame_count_b);
            else n_pass++;
         end
      end
      n_total++;
      if (frame_count_b !== 8'd0) $display("FAIL count_wrap: %0d expected 0", frame_count_b);
      else n_pass++;
      n_total++;
      if (ticks !== 256) $display("FAIL tick_count: %0d expected 256", ticks);
      else n_pass++;
      n_total++;
      if (misplaced !== 0) $display("FAIL tick_place: %0d misplaced expected 0", misplaced);
      else n_pass++;
      n_total++;
      if (vs_first !== 113) $display("FAIL vsync_start: %0d expected 113", vs_first);
      else n_pass++;
      n_total++;
      if (vs_len !== 32) $display("FAIL vsync_width: %0d expected 32", vs_len);
      else n_pass++;
   endtask

   task automatic test_reset_counter;
      repeat (3 * 160 + 50) @(negedge clk);
      n_total++;
      if (frame_count_b !== 8'd3) $display("FAIL count_3: %0d expected 3", frame_count_b);
      else n_pass++;
      rst_b = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({hsync_b, vsync_b, de_b, rgb_b, frame_tick_b, frame_count_b}
          !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 8'd0})
         $display("FAIL reset_b_state: hs=%b vs=%b de=%b rgb=%b tick=%b cnt=%0d expected 1 1 0 000000 0 0",
                  hsync_b, vsync_b, de_b, rgb_b, frame_tick_b, frame_count_b);
      else n_pass++;
      rst_b = 1'b0;
   endtask

   initial begin
      rst_a        = 1'b1;
      rst_b        = 1'b1;
      pattern_mode = 1'b0;
      layer_rgb_a  = 6'b11_10_00;
      test_reset;
      test_h_timing;
      test_window;
      test_colour(1'b0);
      test_colour(1'b1);
      test_frame;
      test_reset_counter;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
